// File: rtl/abs_block_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : abs_block_accumulator
// Description : Streaming |x| accumulator; emits sum, peak and count per block
//               of up to LEN signed samples, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module abs_block_accumulator #(
    parameter int DATA_W = 16,
    parameter int LEN    = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_W-1:0]                    in_data,
    input  logic                                 in_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DATA_W+$clog2(LEN)-1:0]        out_sum,
    output logic [DATA_W-1:0]                    out_max,
    output logic [$clog2(LEN+1)-1:0]             out_count
);

    localparam int CNT_W = $clog2(LEN + 1);
    localparam int SUM_W = DATA_W + $clog2(LEN);
    localparam logic [CNT_W-1:0] C_LEN = CNT_W'(LEN);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t             r_state;
    logic [SUM_W-1:0]   r_acc;
    logic [DATA_W-1:0]  r_peak;
    logic [CNT_W-1:0]   r_count;
    logic               r_out_valid;
    logic [SUM_W-1:0]   r_out_sum;
    logic [DATA_W-1:0]  r_out_max;
    logic [CNT_W-1:0]   r_out_count;

    logic               w_xfer;
    logic [DATA_W-1:0]  w_mag;
    logic [SUM_W-1:0]   w_sum_nxt;
    logic [DATA_W-1:0]  w_peak_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_close;

    // in_ready depends only on state and reset, never on out_ready.
    assign in_ready = (r_state == ST_ACCUM) && !rst;
    assign w_xfer   = in_valid && in_ready;

    // Unsigned negation keeps -2^(DATA_W-1) as exactly 2^(DATA_W-1).
    assign w_mag      = in_data[DATA_W-1] ? (~in_data + 1'b1) : in_data;
    assign w_sum_nxt  = r_acc + {{(SUM_W-DATA_W){1'b0}}, w_mag};
    assign w_peak_nxt = (w_mag > r_peak) ? w_mag : r_peak;
    assign w_cnt_nxt  = r_count + 1'b1;
    assign w_close    = in_last || (w_cnt_nxt == C_LEN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_peak      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_max   <= '0;
            r_out_count <= '0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_xfer) begin
                        if (w_close) begin
                            r_out_sum   <= w_sum_nxt;
                            r_out_max   <= w_peak_nxt;
                            r_out_count <= w_cnt_nxt;
                            r_out_valid <= 1'b1;
                            r_acc       <= '0;
                            r_peak      <= '0;
                            r_count     <= '0;
                            r_state     <= ST_HOLD;
                        end else begin
                            r_acc   <= w_sum_nxt;
                            r_peak  <= w_peak_nxt;
                            r_count <= w_cnt_nxt;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_ACCUM;
                    end
                end
                default: r_state <= ST_ACCUM;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_max   = r_out_max;
    assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_abs_block_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_abs_block_accumulator
// Description : Directed table-driven bench for abs_block_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_abs_block_accumulator;

    localparam int DATA_W = 16;
    localparam int LEN    = 8;
    localparam int CNT_W  = $clog2(LEN + 1);
    localparam int SUM_W  = DATA_W + $clog2(LEN);
    localparam int NVEC   = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_sum;
    logic [DATA_W-1:0] out_max;
    logic [CNT_W-1:0]  out_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string name;
        int    n;
        bit    last_on_end;
        bit    gap;
        int    exp_sum;
        int    exp_max;
        int    exp_cnt;
    } vec_t;

    vec_t vecs [NVEC];
    int   samp [NVEC][LEN];

    abs_block_accumulator #(.DATA_W(DATA_W), .LEN(LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_max   (out_max),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic send(input int d, input bit last, input string tag);
        in_valid = 1'b1;
        in_data  = DATA_W'(d);
        in_last  = last;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, ".out_valid_pre"}, 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_result(input string tag, input int s, input int m, input int c);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".sum"},   32'(out_sum),   32'(s));
        chk({tag, ".max"},   32'(out_max),   32'(m));
        chk({tag, ".count"}, 32'(out_count), 32'(c));
    endtask

    initial begin
        vecs[0] = '{"full",    8, 1'b0, 1'b0, 36,     8,     8};
        vecs[1] = '{"early",   2, 1'b1, 1'b0, 8,      5,     2};
        vecs[2] = '{"single",  1, 1'b1, 1'b0, 4,      4,     1};
        vecs[3] = '{"extreme", 8, 1'b0, 1'b0, 262144, 32768, 8};
        vecs[4] = '{"gapped",  3, 1'b1, 1'b1, 60,     30,    3};
        vecs[5] = '{"zeros",   3, 1'b1, 1'b0, 0,      0,     3};
        vecs[6] = '{"ties",    3, 1'b1, 1'b0, 15,     5,     3};
        samp = '{
            '{1, -2, 3, -4, 5, -6, 7, -8},
            '{-5, 3, 0, 0, 0, 0, 0, 0},
            '{4, 0, 0, 0, 0, 0, 0, 0},
            '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768},
            '{10, -20, 30, 0, 0, 0, 0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0},
            '{5, 5, -5, 0, 0, 0, 0, 0}
        };

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        chk("reset.in_ready",  32'(in_ready),  32'd0);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.out_sum",   32'(out_sum),   32'd0);
        chk("reset.out_max",   32'(out_max),   32'd0);
        chk("reset.out_count", 32'(out_count), 32'd0);
        rst = 1'b0;
        #1;
        chk("reset.in_ready_release", 32'(in_ready), 32'd1);
        tick();

        for (int v = 0; v < NVEC; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                if (vecs[v].gap && i > 0) begin
                    in_valid = 1'b0;
                    in_data  = 16'h7fff;
                    in_last  = 1'b1;
                    tick();
                end
                send(samp[v][i], vecs[v].last_on_end && (i == vecs[v].n - 1), vecs[v].name);
            end
            chk_result(vecs[v].name, vecs[v].exp_sum, vecs[v].exp_max, vecs[v].exp_cnt);
            tick();
            chk({vecs[v].name, ".valid_drop"}, 32'(out_valid), 32'd0);
            chk({vecs[v].name, ".ready_back"}, 32'(in_ready),  32'd1);
        end

        // Backpressure: result held, inputs ignored while HOLD.
        out_ready = 1'b0;
        send(1, 1'b0, "bp");
        send(-2, 1'b0, "bp");
        send(3, 1'b1, "bp");
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 16'd100;
            in_last  = 1'b1;
            chk("bp.in_ready_low", 32'(in_ready), 32'd0);
            chk_result("bp.hold", 6, 3, 3);
            tick();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp.valid_drop", 32'(out_valid), 32'd0);
        chk("bp.ready_rise", 32'(in_ready),  32'd1);
        chk("bp.sum_kept",   32'(out_sum),   32'd6);
        send(7, 1'b1, "bp_next");
        chk_result("bp_next", 7, 7, 1);
        tick();

        // Reset mid-block discards the partial block.
        send(7, 1'b0, "rstmid");
        send(-9, 1'b0, "rstmid");
        rst = 1'b1;
        #1;
        chk("rstmid.in_ready_low", 32'(in_ready), 32'd0);
        tick();
        chk("rstmid.out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1;
        send(2, 1'b1, "rstmid_after");
        chk_result("rstmid_after", 2, 2, 1);
        tick();

        // Reset while HOLD drops the pending result.
        out_ready = 1'b0;
        send(3, 1'b1, "rsthold");
        chk("rsthold.valid_before", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rsthold.out_valid", 32'(out_valid), 32'd0);
        chk("rsthold.out_count", 32'(out_count), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("rsthold.ready", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/abs_block_accumulator.md
Name: abs_block_accumulator

Overview:
- Streaming stage that consumes signed integer samples, forms each sample's absolute value, and accumulates blocks of up to LEN samples.
- Per block it emits the sum of magnitudes, the peak magnitude and the sample count.
- It feeds the package-level helper functions and downstream scalar consumers.
- Valid/ready handshake on both sides.

Parameters:
- DATA_W, 16, signed input sample width (>=2).
- LEN, 8, maximum samples per block (>=2).
- CNT_W, $clog2(LEN+1), width of the sample count (derived, not overridable).
- SUM_W, DATA_W+$clog2(LEN), width of the magnitude sum (derived).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample present.
- in_ready  out  1  stage can accept a sample.
- in_data  in  DATA_W  signed two's-complement sample.
- in_last  in  1  sample closes the current block early.
- out_valid  out  1  block result present.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  SUM_W  unsigned sum of |sample| over the block.
- out_max  out  DATA_W  unsigned peak |sample| in the block.
- out_count  out  CNT_W  number of samples in the block (1..LEN).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - state=ACCUM, accumulator=0, peak=0, count=0.
  - out_valid=0, out_sum=0, out_max=0, out_count=0.
  - in_ready=0 during the reset cycle; in_ready=1 from the first cycle with rst=0.
  - A reset mid-block or while HOLD discards all partial and pending results with no output.
- Magnitude:
  - |x| = x when x>=0, else -x, computed in DATA_W unsigned bits.
  - The most negative value -2^(DATA_W-1) maps to 2^(DATA_W-1) exactly, with no saturation or wrap.
  - The sum never overflows SUM_W.
- Transfers: a transfer occurs when valid & ready are both 1 at a clk edge. in_data and in_last are sampled only on a transfer.
- States:
  - ACCUM: in_ready=1, out_valid=0.
    - On a transfer: accumulator += |x|, peak = max(peak,|x|), count += 1.
    - If in_last=1 or the new count == LEN: register the updated sum, peak and count into the out_* registers, set out_valid=1, clear the internal accumulator, peak and count, and go to HOLD.
    - The result appears the cycle after the closing transfer (latency 1 clk).
  - HOLD: in_ready=0, out_valid=1.
    - out_* are stable until a handshake.
    - On out_ready=1: out_valid=0 next cycle and state returns to ACCUM, so in_ready=1 that same next cycle.
    - Out_* keep their last value after the handshake.
- Single-sample blocks: in_last on the first sample gives count=1, sum=max=|x|.
- Throughput: at most one block every count+1 cycles (HOLD lasts at least 1 cycle). No combinational path from out_ready to in_ready.
- Idle: in_valid=0 holds all state. in_valid may drop between samples without affecting the block.
- Peak ties keep the same value. A block of all zeros gives sum=0, max=0.

Test Plan:
- Full block (DATA_W=16, LEN=8): samples 1,-2,3,-4,5,-6,7,-8 with out_ready=1 -> one result, sum=36, max=8, count=8; out_valid high exactly 1 cycle, one cycle after the 8th transfer.
- Early termination: samples -5,3 with in_last on 3 -> sum=8, max=5, count=2. The next block starts clean: sample 4 with in_last -> sum=4, max=4, count=1.
- Extreme values: eight samples of -32768 -> sum=262144 (0x40000 in 19 bits), max=32768, count=8; no overflow.
- Backpressure: out_ready=0 for 5 cycles after a block closes -> in_ready=0, out_* constant, in_valid ignored. Raise out_ready -> out_valid drops next cycle and in_ready rises that same cycle.
- Gapped input: samples 10,-20,30 with in_valid toggling 1,0,1,0,1 and in_last on 30 -> sum=60, max=30, count=3.
- Reset mid-block: accept 7,-9, assert rst 1 cycle, then send 2 with in_last -> no output for the aborted block; result sum=2, max=2, count=1. Reset while HOLD -> out_valid=0 the next cycle.
